// File: rtl/mio_bus_responder.sv
// Memory/IO bus responder: the far end of the CPU_MIO / MemRW / MIO_ready
// handshake. Decodes each word access to data RAM, the LED/switch port, or
// the free-running cycle counter, inserts per-region wait states, and
// returns read data with a one-cycle MIO_ready pulse.
module mio_bus_responder #(
    parameter int RAM_AW   = 10,
    parameter int WAIT_RAM = 1,
    parameter int WAIT_IO  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CPU_MIO,
    input  logic        MemRW,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    input  logic [15:0] SW_in,
    output logic [15:0] LED_out,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {REG_RAM, REG_LED, REG_CNT, REG_ERR} region_t;

    state_t              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic [RAM_AW-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic                rw_q;
    region_t             region_q;
    logic [31:0]         cyc_cnt;

    region_t             req_region;
    logic [3:0]          req_wait;
    logic                latch_req;
    logic                do_acc;
    logic                acc_rw;
    logic [RAM_AW-1:0]   acc_idx;
    logic [31:0]         acc_wdata;
    region_t             acc_region;
    logic [31:0]         rd_val;

    logic [31:0]         mem [2**RAM_AW];

    function automatic region_t decode(input logic [31:0] a);
        if (a[1:0] != 2'b00)             return REG_ERR;
        else if (a[31:RAM_AW+2] == '0)   return REG_RAM;
        else if (a == 32'hF000_0000)     return REG_LED;
        else if (a == 32'hF000_0004)     return REG_CNT;
        else                             return REG_ERR;
    endfunction

    assign req_region = decode(Addr_out);
    assign req_wait   = (req_region == REG_RAM) ? 4'(WAIT_RAM) : 4'(WAIT_IO);

    assign MIO_ready  = (state_q == S_RESP);
    assign bus_err    = (state_q == S_RESP) && (region_q == REG_ERR);

    // Next-state logic; the access is performed either straight from the
    // live bus inputs (zero wait states) or from the latched copies.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        latch_req  = 1'b0;
        do_acc     = 1'b0;
        acc_rw     = rw_q;
        acc_idx    = idx_q;
        acc_wdata  = wdata_q;
        acc_region = region_q;
        case (state_q)
            S_IDLE: begin
                acc_rw     = MemRW;
                acc_idx    = Addr_out[RAM_AW+1:2];
                acc_wdata  = Data_out;
                acc_region = req_region;
                if (CPU_MIO) begin
                    latch_req = 1'b1;
                    wait_d    = req_wait;
                    if (req_wait == 4'd0) begin
                        do_acc  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q <= 4'd1) begin
                    do_acc  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read value selected by the region of the access being performed.
    always_comb begin
        rd_val = '0;
        case (acc_region)
            REG_RAM: rd_val = mem[acc_idx];
            REG_LED: rd_val = {16'h0000, SW_in};
            REG_CNT: rd_val = cyc_cnt;
            default: rd_val = '0;
        endcase
    end

    // FSM state and wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Request capture in IDLE; later bus changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            region_q <= REG_RAM;
        end else if (latch_req) begin
            idx_q    <= Addr_out[RAM_AW+1:2];
            wdata_q  <= Data_out;
            rw_q     <= MemRW;
            region_q <= req_region;
        end
    end

    // Perform edge: reads load Data_in, LED writes update LED_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Data_in <= '0;
            LED_out <= '0;
        end else if (do_acc) begin
            if (acc_rw) begin
                if (acc_region == REG_LED) LED_out <= acc_wdata[15:0];
            end else begin
                Data_in <= rd_val;
            end
        end
    end

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_cnt <= '0;
        else        cyc_cnt <= cyc_cnt + 32'd1;
    end

    // Data RAM write port (contents are not reset).
    always_ff @(posedge clk) begin
        if (do_acc && acc_rw && (acc_region == REG_RAM)) mem[acc_idx] <= acc_wdata;
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: three instances with different wait-state
// settings. Instance a runs a vector table through a scoreboard; b covers
// reset during a pending write; c covers zero-wait RAM and counter wrap.
module tb_mio_bus_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       mio, rw, rstn, rdy, berr;
    logic [2:0][31:0] addr, wdata, din;
    logic [2:0][15:0] sw, led;

    mio_bus_responder #(.RAM_AW(10), .WAIT_RAM(1), .WAIT_IO(2)) u_a (
        .clk(clk), .rst_n(rstn[0]), .CPU_MIO(mio[0]), .MemRW(rw[0]),
        .Addr_out(addr[0]), .Data_out(wdata[0]), .Data_in(din[0]),
        .MIO_ready(rdy[0]), .SW_in(sw[0]), .LED_out(led[0]), .bus_err(berr[0]));

    mio_bus_responder #(.RAM_AW(10), .WAIT_RAM(3), .WAIT_IO(2)) u_b (
        .clk(clk), .rst_n(rstn[1]), .CPU_MIO(mio[1]), .MemRW(rw[1]),
        .Addr_out(addr[1]), .Data_out(wdata[1]), .Data_in(din[1]),
        .MIO_ready(rdy[1]), .SW_in(sw[1]), .LED_out(led[1]), .bus_err(berr[1]));

    mio_bus_responder #(.RAM_AW(10), .WAIT_RAM(0), .WAIT_IO(2)) u_c (
        .clk(clk), .rst_n(rstn[2]), .CPU_MIO(mio[2]), .MemRW(rw[2]),
        .Addr_out(addr[2]), .Data_out(wdata[2]), .Data_in(din[2]),
        .MIO_ready(rdy[2]), .SW_in(sw[2]), .LED_out(led[2]), .bus_err(berr[2]));

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] sw;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [15:0] exp_led;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          id;
        logic        chk_d;
        logic [31:0] data;
        logic        err;
        logic [15:0] led;
        int          lat;
        int          start;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          tb_cyc = 0;
    exp_t        sbq[$];
    logic [31:0] got_a[$];
    vec_t        vt[16];

    int          lat;
    logic [31:0] rd;
    logic        er;
    exp_t        e, e2;
    int          base;
    logic        found;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [15:0] s, input logic [31:0] xd, input logic xe,
                                input logic [15:0] xl, input int xlat);
        vec_t v;
        v.rw = w; v.addr = a; v.wdata = d; v.sw = s;
        v.exp_data = xd; v.exp_err = xe; v.exp_led = xl; v.exp_lat = xlat;
        return v;
    endfunction

    // One access on instance k; returns measured latency (N+1), data and error.
    task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input exp_t ex, input logic push,
                          output int l, output logic [31:0] r, output logic b);
        exp_t x;
        @(negedge clk);
        rw[k] = w; addr[k] = a; wdata[k] = d; mio[k] = 1'b1;
        if (push) begin
            x = ex;
            x.start = tb_cyc;
            sbq.push_back(x);
        end
        l = -1; r = '0; b = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) mio[k] = 1'b0;
            if (rdy[k]) begin
                l = i; r = din[k]; b = berr[k];
                break;
            end
        end
        if (l < 0) begin
            checks++; errors++;
            $display("FAIL timeout inst %0d addr %h got no ready required ready", k, a);
        end
    endtask

    // Scoreboard for instance a, plus the bus_err-implies-ready rule for all.
    always @(negedge clk) begin
        exp_t x;
        for (int k = 0; k < 3; k++) begin
            if (berr[k] && !rdy[k]) begin
                checks++; errors++;
                $display("FAIL berr_no_ready inst %0d got 1 required 0", k);
            end
        end
        if (rdy[0]) begin
            got_a.push_back(din[0]);
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_ready got 1 required 0");
            end else begin
                x = sbq.pop_front();
                if (x.chk_d) chk($sformatf("a%0d_data", x.id), din[0], x.data);
                chk($sformatf("a%0d_err", x.id), 32'(berr[0]), 32'(x.err));
                chk($sformatf("a%0d_led", x.id), 32'(led[0]), 32'(x.led));
                chk($sformatf("a%0d_lat", x.id), 32'(tb_cyc - x.start), 32'(x.lat));
            end
        end
    end

    initial begin
        mio = '0; rw = '0; rstn = '0; addr = '0; wdata = '0; sw = '0;

        //            rw    addr          wdata         sw       exp_data      err   led       lat
        vt[0]  = mk(1'b1, 32'h0000_0010, 32'h1234_5678, 16'h0000, 32'h0000_0000, 1'b0, 16'h0000, 2);
        vt[1]  = mk(1'b0, 32'h0000_0010, 32'h0,         16'h0000, 32'h1234_5678, 1'b0, 16'h0000, 2);
        vt[2]  = mk(1'b1, 32'hF000_0000, 32'hDEAD_BEEF, 16'h0000, 32'h1234_5678, 1'b0, 16'hBEEF, 3);
        vt[3]  = mk(1'b0, 32'hF000_0000, 32'h0,         16'hA5A5, 32'h0000_A5A5, 1'b0, 16'hBEEF, 3);
        vt[4]  = mk(1'b0, 32'h0000_0002, 32'h0,         16'hA5A5, 32'h0000_0000, 1'b1, 16'hBEEF, 3);
        vt[5]  = mk(1'b1, 32'h8000_0000, 32'hFFFF_0000, 16'hA5A5, 32'h0000_0000, 1'b1, 16'hBEEF, 3);
        vt[6]  = mk(1'b0, 32'h0000_0010, 32'h0,         16'hA5A5, 32'h1234_5678, 1'b0, 16'hBEEF, 2);
        vt[7]  = mk(1'b1, 32'hF000_0004, 32'h0000_0055, 16'hA5A5, 32'h1234_5678, 1'b0, 16'hBEEF, 3);
        vt[8]  = mk(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 16'hA5A5, 32'h1234_5678, 1'b0, 16'hBEEF, 2);
        vt[9]  = mk(1'b0, 32'h0000_0FFC, 32'h0,         16'hA5A5, 32'hCAFE_F00D, 1'b0, 16'hBEEF, 2);
        vt[10] = mk(1'b0, 32'h0000_1000, 32'h0,         16'hA5A5, 32'h0000_0000, 1'b1, 16'hBEEF, 3);
        vt[11] = mk(1'b1, 32'h0000_1010, 32'h0BAD_BEEF, 16'hA5A5, 32'h0000_0000, 1'b1, 16'hBEEF, 3);
        vt[12] = mk(1'b0, 32'h0000_0010, 32'h0,         16'hA5A5, 32'h1234_5678, 1'b0, 16'hBEEF, 2);
        vt[13] = mk(1'b1, 32'hF000_0001, 32'h0000_1111, 16'hA5A5, 32'h1234_5678, 1'b1, 16'hBEEF, 3);
        vt[14] = mk(1'b0, 32'hF000_0000, 32'h0,         16'h1234, 32'h0000_1234, 1'b0, 16'hBEEF, 3);
        vt[15] = mk(1'b1, 32'hF000_0000, 32'h0000_5A5A, 16'h1234, 32'h0000_1234, 1'b0, 16'h5A5A, 3);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_ready", k), 32'(rdy[k]),  32'h0);
            chk($sformatf("rst%0d_err", k),   32'(berr[k]), 32'h0);
            chk($sformatf("rst%0d_data", k),  din[k],       32'h0);
            chk($sformatf("rst%0d_led", k),   32'(led[k]),  32'h0);
        end
        rstn = '1;
        repeat (2) @(negedge clk);

        // Instance a: vector table through the scoreboard.
        for (int i = 0; i < 16; i++) begin
            sw[0] = vt[i].sw;
            e = '{i, 1'b1, vt[i].exp_data, vt[i].exp_err, vt[i].exp_led, vt[i].exp_lat, 0};
            access(0, vt[i].rw, vt[i].addr, vt[i].wdata, e, 1'b1, lat, rd, er);
        end

        // Instance a: back-to-back counter reads with CPU_MIO held high.
        @(negedge clk);
        base = got_a.size();
        rw[0] = 1'b0; addr[0] = 32'hF000_0004; mio[0] = 1'b1;
        e  = '{100, 1'b0, 32'h0, 1'b0, 16'h5A5A, 3, tb_cyc};
        e2 = '{101, 1'b0, 32'h0, 1'b0, 16'h5A5A, 3, tb_cyc + 4};
        sbq.push_back(e);
        sbq.push_back(e2);
        repeat (5) @(negedge clk);
        mio[0] = 1'b0;
        for (int i = 0; i < 20 && got_a.size() < base + 2; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk("a_b2b_pulses", 32'(got_a.size() - base), 32'd2);
        if (got_a.size() >= base + 2)
            chk("a_b2b_delta", got_a[base+1] - got_a[base], 32'd4);
        chk("a_sb_empty", 32'(sbq.size()), 32'd0);

        // Instance b (WAIT_RAM=3): reset during a pending write abandons it.
        e = '{0, 1'b0, 32'h0, 1'b0, 16'h0, 0, 0};
        access(1, 1'b1, 32'hF000_0000, 32'h0000_00FF, e, 1'b0, lat, rd, er);
        chk("b_led_lat", 32'(lat), 32'd3);
        chk("b_led", 32'(led[1]), 32'h0000_00FF);
        access(1, 1'b1, 32'h0000_0020, 32'h1111_2222, e, 1'b0, lat, rd, er);
        chk("b_wr_lat", 32'(lat), 32'd4);
        access(1, 1'b0, 32'h0000_0020, 32'h0, e, 1'b0, lat, rd, er);
        chk("b_rd_lat", 32'(lat), 32'd4);
        chk("b_rd_data", rd, 32'h1111_2222);
        @(negedge clk);
        rw[1] = 1'b1; addr[1] = 32'h0000_0020; wdata[1] = 32'h9999_8888; mio[1] = 1'b1;
        @(negedge clk);
        mio[1] = 1'b0;
        @(negedge clk);
        rstn[1] = 1'b0;
        #1;
        chk("b_abort_ready", 32'(rdy[1]), 32'h0);
        chk("b_abort_err",   32'(berr[1]), 32'h0);
        chk("b_abort_data",  din[1], 32'h0);
        chk("b_abort_led",   32'(led[1]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("b_rst_noready%0d", i), 32'(rdy[1]), 32'h0);
        end
        rstn[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("b_post_noready%0d", i), 32'(rdy[1]), 32'h0);
        end
        access(1, 1'b0, 32'h0000_0020, 32'h0, e, 1'b0, lat, rd, er);
        chk("b_kept_data", rd, 32'h1111_2222);
        chk("b_kept_err", 32'(er), 32'h0);

        // Instance c (WAIT_RAM=0): immediate RAM response, IO path, counter wrap.
        access(2, 1'b1, 32'h0000_0040, 32'h0F0F_0F0F, e, 1'b0, lat, rd, er);
        chk("c_wr_lat", 32'(lat), 32'd1);
        access(2, 1'b0, 32'h0000_0040, 32'h0, e, 1'b0, lat, rd, er);
        chk("c_rd_lat", 32'(lat), 32'd1);
        chk("c_rd_data", rd, 32'h0F0F_0F0F);
        sw[2] = 16'h5A5A;
        access(2, 1'b0, 32'hF000_0000, 32'h0, e, 1'b0, lat, rd, er);
        chk("c_sw_lat", 32'(lat), 32'd3);
        chk("c_sw_data", rd, 32'h0000_5A5A);
        access(2, 1'b0, 32'h0000_0043, 32'h0, e, 1'b0, lat, rd, er);
        chk("c_mis_err", 32'(er), 32'h1);
        chk("c_mis_data", rd, 32'h0);

        @(negedge clk);
        force u_c.cyc_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release u_c.cyc_cnt;
        #1;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (u_c.cyc_cnt == 32'hFFFF_FFFF) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("c_cnt_max", 32'(found), 32'h1);
        if (found) begin
            @(posedge clk);
            #1;
            chk("c_cnt_wrap", u_c.cyc_cnt, 32'h0);
            access(2, 1'b0, 32'hF000_0004, 32'h0, e, 1'b0, lat, rd, er);
            chk("c_cnt_read", rd, 32'h0000_0002);
            chk("c_cnt_lat", 32'(lat), 32'd3);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
